// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter (reverse double-dabble).
// Converts one bit per clock and uses a start/done handshake.
// It flags invalid digits (Error) and results too wide for BIN_W bits (Overflow).
// Optional build macro: BCD2BIN_SAT_EN. When it is defined, an overflowing
// result saturates to all ones. When it is undefined, the result wraps modulo 2**BIN_W.
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Done,
  output logic [BIN_W-1:0]      Binary,
  output logic                  Error,
  output logic                  Overflow
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    sreg, acc;
  logic [W-1:0]    sreg_nx, acc_nx;
  logic [CW-1:0]   cnt;
  logic            load;
  logic            bad;
  logic            last;
  logic            ovf_nx;
  logic [BIN_W-1:0] bin_nx;

  assign last = (cnt == CW'(W - 1));

  // One reverse double-dabble step, plus detection of invalid digits in the captured word
  always_comb begin
    acc_nx  = {sreg[0], acc[W-1:1]};
    sreg_nx = {1'b0, sreg[W-1:1]};
    bad     = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sreg_nx[4*i +: 4] >= 4'd8)
        sreg_nx[4*i +: 4] = sreg_nx[4*i +: 4] - 4'd3;
      if (sreg[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
  end

  // The result window and overflow bits depend on whether BIN_W covers the accumulator
  generate
    if (BIN_W < W) begin : g_narrow
      assign ovf_nx = |acc_nx[W-1:BIN_W];
      assign bin_nx = acc_nx[BIN_W-1:0];
    end else begin : g_wide
      assign ovf_nx = 1'b0;
      assign bin_nx = BIN_W'(acc_nx);
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nx = state;
    Ready    = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    load     = 1'b0;
    case (state)
      S_IDLE: begin
        Ready = 1'b1;
        if (Start) begin
          load     = 1'b1;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        Busy     = 1'b1;
        state_nx = bad ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        Busy = 1'b1;
        if (last)
          state_nx = S_DONE;
      end
      S_DONE: begin
        Done  = 1'b1;
        Ready = 1'b1;
        if (Start) begin
          load     = 1'b1;
          state_nx = S_CHECK;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: capture, shift, and result registers.
  // The valid path does not clear Error/Overflow in CHECK. They are written only on
  // the edge entering DONE, so results stay stable until the next DONE entry. The
  // final values are identical either way.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      Binary   <= '0;
      Error    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (load) begin
        sreg <= BCD;
        acc  <= '0;
      end
      case (state)
        S_CHECK: begin
          cnt <= '0;
          if (bad) begin
            Binary   <= '1;
            Error    <= 1'b1;
            Overflow <= 1'b0;
          end
        end
        S_SHIFT: begin
          sreg <= sreg_nx;
          acc  <= acc_nx;
          cnt  <= cnt + 1'b1;
          if (last) begin
            Error    <= 1'b0;
            Overflow <= ovf_nx;
`ifdef BCD2BIN_SAT_EN
            Binary   <= ovf_nx ? '1 : bin_nx;
`else
            Binary   <= bin_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed self-checking bench for bcd2bin_seq (DIGITS=4, BIN_W=12).
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [15:0] BCD;
  logic        Ready, Busy, Done, Error, Overflow;
  logic [11:0] Binary;

  int n_checks = 0;
  int n_fails  = 0;

  localparam int LAT_VALID = 17;  // edges after the accepting edge until Done is visible
  localparam int LAT_BAD   = 1;
  localparam int LIMIT     = 40;

`ifdef BCD2BIN_SAT_EN
  localparam logic [11:0] EXP_9999 = 12'hFFF;
  localparam logic [11:0] EXP_4096 = 12'hFFF;
`else
  localparam logic [11:0] EXP_9999 = 12'h70F;
  localparam logic [11:0] EXP_4096 = 12'h000;
`endif

  bcd2bin_seq #(.DIGITS(4), .BIN_W(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .BCD      (BCD),
    .Ready    (Ready),
    .Busy     (Busy),
    .Done     (Done),
    .Binary   (Binary),
    .Error    (Error),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Pulses Start for one edge, then waits (bounded) for Done.
  // It returns at the negedge where Done is seen. lat counts edges after the accepting edge.
  task automatic convert(input logic [15:0] v, output int lat);
    Start = 1'b1;
    BCD   = v;
    @(negedge clk);
    Start = 1'b0;
    check("busy_after_accept", Busy, 1'b1);
    lat = 0;
    while (!Done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] v, input int exp_lat,
                     input logic [11:0] exp_bin, input logic exp_err, input logic exp_ovf);
    int lat;
    convert(v, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_bin"}, Binary, exp_bin);
    check({tag, "_err"}, Error, exp_err);
    check({tag, "_ovf"}, Overflow, exp_ovf);
    check({tag, "_ready_in_done"}, Ready, 1'b1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, Done, 1'b0);
  endtask

  initial begin
    int lat;
    int seen;
    rst   = 1'b1;
    Start = 1'b0;
    BCD   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", Ready, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_bin", Binary, 12'h000);
    check("rst_err", Error, 1'b0);
    check("rst_ovf", Overflow, 1'b0);

    // Directed vectors
    run("v1234", 16'h1234, LAT_VALID, 12'h4D2, 1'b0, 1'b0);
    run("v0000", 16'h0000, LAT_VALID, 12'h000, 1'b0, 1'b0);
    run("v4095", 16'h4095, LAT_VALID, 12'hFFF, 1'b0, 1'b0);
    run("v4096", 16'h4096, LAT_VALID, EXP_4096, 1'b0, 1'b1);
    run("v9999", 16'h9999, LAT_VALID, EXP_9999, 1'b0, 1'b1);
    run("v0099", 16'h0099, LAT_VALID, 12'h063, 1'b0, 1'b0);
    run("v12A4", 16'h12A4, LAT_BAD, 12'hFFF, 1'b1, 1'b0);
    run("vF000", 16'hF000, LAT_BAD, 12'hFFF, 1'b1, 1'b0);
    run("v000A", 16'h000A, LAT_BAD, 12'hFFF, 1'b1, 1'b0);
    run("v0001", 16'h0001, LAT_VALID, 12'h001, 1'b0, 1'b0);

    // Result is held while idle, even when BCD changes
    BCD = 16'h5555;
    repeat (5) @(negedge clk);
    check("hold_bin", Binary, 12'h001);

    // Start re-pulsed mid-conversion with a new word: ignored
    Start = 1'b1;
    BCD   = 16'h1234;
    @(negedge clk);
    Start = 1'b0;
    lat = 0;
    while (!Done && lat < LIMIT) begin
      if (lat == 4) begin
        Start = 1'b1;
        BCD   = 16'h0042;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    Start = 1'b0;
    check("ign_lat", lat, LAT_VALID);
    check("ign_bin", Binary, 12'h4D2);
    @(negedge clk);

    // Back-to-back: Start is raised while in DONE, and the next conversion needs no IDLE cycle
    convert(16'h0250, lat);
    check("b2b1_lat", lat, LAT_VALID);
    check("b2b1_bin", Binary, 12'h0FA);
    convert(16'h0512, lat);
    check("b2b2_lat", lat, LAT_VALID);
    check("b2b2_bin", Binary, 12'h200);
    @(negedge clk);

    // Reset mid-SHIFT discards the conversion, and no Done pulse follows
    Start = 1'b1;
    BCD   = 16'h0777;
    @(negedge clk);
    Start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", Busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_ready", Ready, 1'b1);
    check("mid_rst_bin", Binary, 12'h000);
    check("mid_rst_err", Error, 1'b0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (Done) seen++;
    end
    check("mid_rst_no_done", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
